muldiv_unit: RTL



---
 rtl/muldiv_unit_pkg.sv | 36 +++
 rtl/muldiv_unit_if.sv | 33 +++
 rtl/muldiv_unit_div_restoring_step.sv | 30 +++
 rtl/muldiv_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
//  Module   : muldiv_unit_pkg
//  Brief    : Shared op and state encodings for the iterative mul/div unit.
//             Optional feature macro: MULDIV_FAST_MUL_EN (see muldiv_unit).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

    // Op encodings as emitted by the ALU control decoder
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Engine states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // op[1] selects divide, op[0] selects unsigned
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_if.sv
// ============================================================================
//  Module   : muldiv_unit_if
//  Brief    : Request/response bundle between execute stage and mul/div unit.
//             master = pipeline side, slave = mul/div engine.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [1:0]             op;
    logic [WIDTH-1:0]       srca;
    logic [WIDTH-1:0]       srcb;
    logic                   cancel;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     result;
    logic                   dbz;

    modport master (
        output start, op, srca, srcb, cancel,
        input  busy, done, result, dbz
    );

    modport slave (
        input  start, op, srca, srcb, cancel,
        output busy, done, result, dbz
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit_div_restoring_step.sv
// ============================================================================
//  Module   : div_restoring_step
//  Brief    : One combinational restoring-division iteration. Shifts the next
//             dividend bit into the partial remainder, trial-subtracts the
//             divisor and restores on borrow.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] rem_in,
    input  wire logic [WIDTH-1:0] divisor,
    input  wire logic             dividend_bit,
    output logic      [WIDTH-1:0] rem_out,
    output logic                  q_bit
);

    logic [WIDTH:0] w_shift;

    assign w_shift = {rem_in, dividend_bit};
    // Trial subtract on WIDTH+1 bits; no borrow means the quotient bit is 1
    assign q_bit   = (w_shift >= {1'b0, divisor});
    // The kept difference is always below the divisor, so it fits WIDTH bits
    assign rem_out = q_bit ? WIDTH'(w_shift - {1'b0, divisor}) : w_shift[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module   : muldiv_unit
//  Brief    : Iterative MULT/MULTU/DIV/DIVU engine producing {hi,lo}.
//             Radix-2 shift-add multiply, restoring divide, WIDTH+2 latency.
//             Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one
//             cycle through a combinational product, divide unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  wire logic     clk,
    input  wire logic     rst,
    muldiv_unit_if.slave  bus
);
    import muldiv_unit_pkg::*;

    state_t                 r_state;
    state_t                 w_next_state;

    logic                   r_is_div;
    logic                   r_sa;
    logic                   r_sb;
    logic                   r_dbz_pend;
    logic [WIDTH-1:0]       r_srca;
    logic [WIDTH-1:0]       r_b;          // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]     r_acc;        // mul: {acc, multiplier}; div: {rem, quo}
    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_result;
    logic                   r_dbz;

    logic                   w_accept;
    logic                   w_fast_mul;
    logic                   w_last;
    logic                   w_sa;
    logic                   w_sb;
    logic [WIDTH-1:0]       w_abs_a;
    logic [WIDTH-1:0]       w_abs_b;
    logic [WIDTH:0]         w_mul_sum;
    logic [WIDTH-1:0]       w_rem_next;
    logic                   w_qbit;
    logic [2*WIDTH-1:0]     w_fix_result;
    logic                   w_fix_dbz;

    // ---------------------------------------------------------------------
    // Accept and operand preparation
    // ---------------------------------------------------------------------
    assign w_accept = bus.start && !bus.cancel &&
                      ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_cnt == CNT_W'(WIDTH-1));

    assign w_sa     = op_is_signed(bus.op) & bus.srca[WIDTH-1];
    assign w_sb     = op_is_signed(bus.op) & bus.srcb[WIDTH-1];
    assign w_abs_a  = w_sa ? (~bus.srca + WIDTH'(1)) : bus.srca;
    assign w_abs_b  = w_sb ? (~bus.srcb + WIDTH'(1)) : bus.srcb;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0]     w_ext_a;
    logic [2*WIDTH-1:0]     w_ext_b;
    logic [2*WIDTH-1:0]     w_fast_prod;

    // Sign/zero extension to 2*WIDTH makes one modular multiply serve both
    assign w_ext_a     = {{WIDTH{w_sa}}, bus.srca};
    assign w_ext_b     = {{WIDTH{w_sb}}, bus.srcb};
    assign w_fast_prod = w_ext_a * w_ext_b;
    assign w_fast_mul  = ~op_is_div(bus.op);
`else
    assign w_fast_mul  = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Per-cycle iteration datapath
    // ---------------------------------------------------------------------
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                       (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

    div_restoring_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in       (r_acc[2*WIDTH-1:WIDTH]),
        .divisor      (r_b),
        .dividend_bit (r_acc[WIDTH-1]),
        .rem_out      (w_rem_next),
        .q_bit        (w_qbit)
    );

    // ---------------------------------------------------------------------
    // Sign correction and divide-by-zero override
    // ---------------------------------------------------------------------
    // Final result formatting applied in FIX
    always_comb begin
        w_fix_result = r_acc;
        w_fix_dbz    = 1'b0;
        if (r_is_div) begin
            if (r_dbz_pend) begin
                w_fix_result = {r_srca, {WIDTH{1'b1}}};
                w_fix_dbz    = 1'b1;
            end else begin
                w_fix_result[2*WIDTH-1:WIDTH] = r_sa ? (~r_acc[2*WIDTH-1:WIDTH] + WIDTH'(1))
                                                     : r_acc[2*WIDTH-1:WIDTH];
                w_fix_result[WIDTH-1:0]       = (r_sa ^ r_sb) ? (~r_acc[WIDTH-1:0] + WIDTH'(1))
                                                              : r_acc[WIDTH-1:0];
            end
        end else if (r_sa ^ r_sb) begin
            w_fix_result = ~r_acc + (2*WIDTH)'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; cancel overrides every transition
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = w_fast_mul ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (w_last) w_next_state = ST_FIX;
            end
            ST_FIX: begin
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (w_accept) w_next_state = w_fast_mul ? ST_DONE : ST_RUN;
                else          w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (bus.cancel) w_next_state = ST_IDLE;
    end

    // Operand latch at accept and one radix-2 step per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_div   <= 1'b0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_srca     <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_is_div   <= op_is_div(bus.op);
            r_sa       <= w_sa;
            r_sb       <= w_sb;
            r_dbz_pend <= op_is_div(bus.op) && (bus.srcb == '0);
            r_srca     <= bus.srca;
            r_cnt      <= '0;
            if (op_is_div(bus.op)) begin
                r_acc <= {{WIDTH{1'b0}}, w_abs_a};
                r_b   <= w_abs_b;
            end else begin
                r_acc <= {{WIDTH{1'b0}}, w_abs_b};
                r_b   <= w_abs_a;
            end
        end else if ((r_state == ST_RUN) && !bus.cancel) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_div) r_acc <= {w_rem_next, r_acc[WIDTH-2:0], w_qbit};
            else          r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
        end
    end

    // Result and dbz update only on completion; cancel leaves them intact
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else if ((r_state == ST_FIX) && !bus.cancel) begin
            r_result <= w_fix_result;
            r_dbz    <= w_fix_dbz;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (w_accept && w_fast_mul) begin
            r_result <= w_fast_prod;
            r_dbz    <= 1'b0;
        end
`endif
    end

    assign bus.busy   = (r_state == ST_RUN) || (r_state == ST_FIX);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.result = r_result;
    assign bus.dbz    = r_dbz;

endmodule

`default_nettype wire
